// File: rtl/ysyx_23060236_tlb_pkg.sv
// ysyx_23060236_tlb_pkg: shared widths, entry type and index-width helper for the TLB
package ysyx_23060236_tlb_pkg;
  localparam int VPN_W = 20;
  localparam int PPN_W = 20;
  typedef struct packed {
    logic             valid;
    logic [VPN_W-1:0] vpn;
    logic [PPN_W-1:0] ppn;
  } tlb_entry_t;
  function automatic int TLB_IDX_W(input int entries);
    return (entries > 1) ? $clog2(entries) : 1;
  endfunction
endpackage

// File: rtl/ysyx_23060236_tlb_victim.sv
// ysyx_23060236_tlb_victim: refill slot choice (in-place, first free, else round-robin) and rr_ptr
module ysyx_23060236_tlb_victim
  import ysyx_23060236_tlb_pkg::*;
#(
  parameter int ENTRIES = 8,
  localparam int IW = TLB_IDX_W(ENTRIES)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  input  logic               step,
  input  logic [ENTRIES-1:0] valid,
  input  logic [ENTRIES-1:0] match,
  output logic [IW-1:0]      widx,
  output logic               adv
);
  logic [IW-1:0] rr_ptr, hit_idx, free_idx;
  always_comb begin
    hit_idx  = '0;
    free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (match[i]) hit_idx = IW'(i);
      if (!valid[i]) free_idx = IW'(i);
    end
  end
  assign adv  = ~|match & &valid;
  assign widx = |match ? hit_idx : (&valid ? rr_ptr : free_idx);
  always_ff @(posedge clock) begin
    if (reset || flush) rr_ptr <= '0;
    else if (step) rr_ptr <= rr_ptr + IW'(1);
  end
endmodule

// File: rtl/ysyx_23060236_tlb.sv
// ysyx_23060236_tlb: fully associative Sv32 TLB, combinational lookup, round-robin refill.
// Define YSYX_23060236_TLB_WFWD_EN to forward a same-cycle refill to the lookup port.
module ysyx_23060236_tlb
  import ysyx_23060236_tlb_pkg::*;
#(
  parameter int ENTRIES = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [VPN_W-1:0] tlb_araddr,
  output logic [PPN_W-1:0] tlb_rdata,
  output logic             tlb_hit,
  input  logic [VPN_W-1:0] tlb_awaddr,
  input  logic [PPN_W-1:0] tlb_wdata,
  input  logic             tlb_wvalid,
  input  logic             tlb_flush
);
  localparam int IW = TLB_IDX_W(ENTRIES);
  tlb_entry_t         ent [ENTRIES];
  logic [ENTRIES-1:0] valid, rmatch, wmatch;
  logic [IW-1:0]      widx;
  logic               adv, wen, fwd;
  logic [PPN_W-1:0]   rd;
  assign wen = tlb_wvalid & ~tlb_flush;
  for (genvar g = 0; g < ENTRIES; g++) begin : g_cmp
    assign valid[g]  = ent[g].valid;
    assign rmatch[g] = ent[g].valid & (ent[g].vpn == tlb_araddr);
    assign wmatch[g] = ent[g].valid & (ent[g].vpn == tlb_awaddr);
  end
  always_comb begin
    rd = '0;
    for (int i = ENTRIES - 1; i >= 0; i--)
      if (rmatch[i]) rd = ent[i].ppn;
  end
`ifdef YSYX_23060236_TLB_WFWD_EN
  assign fwd = wen & (tlb_awaddr == tlb_araddr);
`else
  assign fwd = 1'b0;
`endif
  assign tlb_hit   = fwd | |rmatch;
  assign tlb_rdata = fwd ? tlb_wdata : rd;
  ysyx_23060236_tlb_victim #(.ENTRIES(ENTRIES)) u_vic (
    .clock (clock),
    .reset (reset),
    .flush (tlb_flush),
    .step  (wen & adv),
    .valid (valid),
    .match (wmatch),
    .widx  (widx),
    .adv   (adv)
  );
  always_ff @(posedge clock) begin
    if (reset || tlb_flush) begin
      for (int i = 0; i < ENTRIES; i++) ent[i].valid <= 1'b0;
    end else if (tlb_wvalid) begin
      ent[widx] <= {1'b1, tlb_awaddr, tlb_wdata};
    end
  end
endmodule

// File: tb/tb_ysyx_23060236_tlb.sv
// tb_ysyx_23060236_tlb: directed plus model-driven random checks of the TLB through a scoreboard queue
module tb_ysyx_23060236_tlb;
  localparam int N = 8;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [19:0] tlb_araddr = '0, tlb_awaddr = '0, tlb_wdata = '0, tlb_rdata;
  logic        tlb_hit, tlb_wvalid = 1'b0, tlb_flush = 1'b0;
  int          checks = 0, errors = 0;
  logic [20:0] sb [$];
  logic        m_v   [N];
  logic [19:0] m_vpn [N];
  logic [19:0] m_ppn [N];
  int          m_rr;

  ysyx_23060236_tlb #(.ENTRIES(N)) dut (
    .clock      (clock),
    .reset      (reset),
    .tlb_araddr (tlb_araddr),
    .tlb_rdata  (tlb_rdata),
    .tlb_hit    (tlb_hit),
    .tlb_awaddr (tlb_awaddr),
    .tlb_wdata  (tlb_wdata),
    .tlb_wvalid (tlb_wvalid),
    .tlb_flush  (tlb_flush)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  function automatic logic [20:0] m_look(input logic [19:0] a);
    for (int i = 0; i < N; i++)
      if (m_v[i] && m_vpn[i] == a) return {1'b1, m_ppn[i]};
    return 21'd0;
  endfunction

  task automatic m_fill(input logic [19:0] a, input logic [19:0] d);
    int w = -1;
    for (int i = 0; i < N; i++) if (w < 0 && m_v[i] && m_vpn[i] == a) w = i;
    for (int i = 0; i < N; i++) if (w < 0 && !m_v[i]) w = i;
    if (w < 0) begin
      w = m_rr;
      m_rr = (m_rr + 1) % N;
    end
    m_v[w] = 1'b1;
    m_vpn[w] = a;
    m_ppn[w] = d;
  endtask

  task automatic m_flush();
    for (int i = 0; i < N; i++) m_v[i] = 1'b0;
    m_rr = 0;
  endtask

  task automatic compare(input string tag);
    logic [20:0] exp;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL %s: scoreboard empty, observed hit=%0b rdata=%h", tag, tlb_hit, tlb_rdata);
      return;
    end
    exp = sb.pop_front();
    checks++;
    assert ({tlb_hit, tlb_rdata} === exp) else begin
      errors++;
      $error("FAIL %s: observed hit=%0b rdata=%h expected hit=%0b rdata=%h",
             tag, tlb_hit, tlb_rdata, exp[20], exp[19:0]);
    end
  endtask

  task automatic look(input logic [19:0] a, input logic eh, input logic [19:0] ed, input string tag);
    @(negedge clock);
    tlb_araddr = a;
    sb.push_back({eh, ed});
    #1 compare(tag);
  endtask

  task automatic check_rr(input logic [2:0] exp, input string tag);
    checks++;
    assert (dut.u_vic.rr_ptr === exp) else begin
      errors++;
      $error("FAIL %s: observed rr_ptr=%0d expected rr_ptr=%0d", tag, dut.u_vic.rr_ptr, exp);
    end
  endtask

  task automatic refill(input logic [19:0] a, input logic [19:0] d);
    @(negedge clock);
    tlb_awaddr = a;
    tlb_wdata  = d;
    tlb_wvalid = 1'b1;
    @(posedge clock);
    #1 tlb_wvalid = 1'b0;
    m_fill(a, d);
  endtask

  task automatic flush(input logic w, input logic [19:0] a);
    @(negedge clock);
    tlb_flush  = 1'b1;
    tlb_wvalid = w;
    tlb_awaddr = a;
    tlb_wdata  = 20'h55555;
    @(posedge clock);
    #1;
    tlb_flush  = 1'b0;
    tlb_wvalid = 1'b0;
    m_flush();
  endtask

  initial begin
    logic [20:0] r;
    m_flush();
    tlb_wvalid = 1'b1;
    tlb_awaddr = 20'h12345;
    tlb_wdata  = 20'h00001;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    tlb_wvalid = 1'b0;
    check_rr(3'd0, "reset_rr");
    look(20'h12345, 1'b0, 20'h0, "reset_miss");

    refill(20'h12345, 20'h80001);
    look(20'h12345, 1'b1, 20'h80001, "refill_hit");
    look(20'h12346, 1'b0, 20'h0, "neighbour_miss");
    check_rr(3'd0, "rr_after_free_fill");

    @(negedge clock);
    tlb_flush  = 1'b1;
    tlb_araddr = 20'h12345;
    sb.push_back({1'b1, 20'h80001});
    #1 compare("flush_cycle_old");
    @(posedge clock);
    #1 tlb_flush = 1'b0;
    m_flush();
    look(20'h12345, 1'b0, 20'h0, "after_flush_miss");

    for (int i = 1; i <= 8; i++) refill(20'(i), 20'h00100 + 20'(i));
    check_rr(3'd0, "rr_full_no_evict");
    look(20'h00008, 1'b1, 20'h00108, "fill8_hit");
    refill(20'h00009, 20'h00109);
    check_rr(3'd1, "rr_after_evict0");
    look(20'h00001, 1'b0, 20'h0, "evicted_vpn1");
    look(20'h00009, 1'b1, 20'h00109, "new_vpn9");
    look(20'h00002, 1'b1, 20'h00102, "kept_vpn2");
    refill(20'h0000A, 20'h0010A);
    check_rr(3'd2, "rr_after_evict1");
    look(20'h00002, 1'b0, 20'h0, "evicted_vpn2");
    look(20'h0000A, 1'b1, 20'h0010A, "new_vpnA");

    refill(20'h00003, 20'h7FFFF);
    check_rr(3'd2, "rr_inplace_unchanged");
    look(20'h00003, 1'b1, 20'h7FFFF, "inplace_ppn");
    refill(20'h0000B, 20'h0010B);
    check_rr(3'd3, "rr_after_evict2");
    look(20'h00003, 1'b0, 20'h0, "no_duplicate_vpn3");
    look(20'h0000B, 1'b1, 20'h0010B, "new_vpnB");
    look(20'h00004, 1'b1, 20'h00104, "kept_vpn4");

    flush(1'b1, 20'h0000C);
    check_rr(3'd0, "flush_wins_rr");
    look(20'h0000C, 1'b0, 20'h0, "flush_drops_refill");
    look(20'h00009, 1'b0, 20'h0, "flush_vpn9");
    look(20'h00004, 1'b0, 20'h0, "flush_vpn4");

    @(negedge clock);
    tlb_wvalid = 1'b1;
    tlb_awaddr = 20'h0ABCD;
    tlb_araddr = 20'h0ABCD;
    tlb_wdata  = 20'h00042;
`ifdef YSYX_23060236_TLB_WFWD_EN
    sb.push_back({1'b1, 20'h00042});
`else
    sb.push_back(21'd0);
`endif
    #1 compare("same_cycle_lookup");
    @(posedge clock);
    #1 tlb_wvalid = 1'b0;
    m_fill(20'h0ABCD, 20'h00042);
    look(20'h0ABCD, 1'b1, 20'h00042, "next_cycle_hit");

    repeat (200) begin
      int op;
      logic [19:0] a;
      op = $urandom_range(0, 11);
      a  = 20'($urandom_range(0, 11));
      if (op < 5) begin
        refill(a, 20'($urandom));
        check_rr(3'(m_rr), "rand_rr");
      end else if (op == 5) begin
        flush(1'($urandom_range(0, 1)), a);
      end else begin
        r = m_look(a);
        look(a, r[20], r[19:0], "rand_lookup");
      end
    end

    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    m_flush();
    check_rr(3'd0, "late_reset_rr");
    for (int i = 0; i < 4; i++) look(20'(i), 1'b0, 20'h0, "late_reset_miss");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ysyx_23060236_tlb.md
# ysyx_23060236_tlb

Fully associative translation lookaside buffer serving the MMU's `tlb_*` port: it answers lookups combinationally in the same cycle and accepts refill writes from the page walker. It stores VPN→PPN pairs for Sv32 4 KiB pages, with round-robin replacement and a whole-buffer flush. It sits beside the MMU in the core's memory path and has no bus interface of its own.

## Interface
- `ENTRIES`, default 8: number of entries; power of two, 2..32.
- `clock` input 1: the single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `tlb_araddr` input 20: lookup VPN {vpn1, vpn0}.
- `tlb_rdata` output 20: PPN of the matching entry; 0 on a miss.
- `tlb_hit` output 1: a valid entry matches `tlb_araddr`.
- `tlb_awaddr` input 20: refill VPN.
- `tlb_wdata` input 20: refill PPN, which is PTE[29:10].
- `tlb_wvalid` input 1: single-cycle refill strobe.
- `tlb_flush` input 1: invalidate all entries (sfence.vma or satp write).

## Operation
- Per-entry state: `valid`, `vpn[19:0]`, `ppn[19:0]`. Victim pointer `rr_ptr`, width log2(ENTRIES).
- Lookup is purely combinational from `tlb_araddr` and current entry state, with no clock involvement.
  - `tlb_hit` = OR over entries of (`valid` & `vpn == tlb_araddr`).
  - `tlb_rdata` = `ppn` of the lowest-index matching entry. Duplicates are never created, so one match at most is expected.
- Refill on a clock edge with `tlb_wvalid`=1 and `tlb_flush`=0:
  - If a valid entry already holds `tlb_awaddr`, overwrite its `ppn` in place. `rr_ptr` is unchanged.
  - Otherwise, if any entry is invalid, write the lowest-index invalid entry. `rr_ptr` is unchanged.
  - Otherwise, write entry `rr_ptr` and set `rr_ptr` ← `rr_ptr`+1, wrapping modulo ENTRIES.
  - The written entry becomes valid with `vpn`=`tlb_awaddr` and `ppn`=`tlb_wdata`.
- Flush on a clock edge with `tlb_flush`=1: clear all `valid` bits and set `rr_ptr` ← 0.
  - Flush wins over a simultaneous `tlb_wvalid`; the refill is dropped.
  - `vpn` and `ppn` contents are don't-care after a flush.
- Reset: all `valid` ← 0, `rr_ptr` ← 0. `tlb_hit`=0 and `tlb_rdata`=0 from the first cycle after reset.
  - Reset during a refill drops the refill.
- No permission, ASID or global bits are stored. Translation context changes must go through `tlb_flush`.

## Timing
- Lookup latency is 0 cycles: `tlb_hit`/`tlb_rdata` are valid in the same cycle `tlb_araddr` is stable. The MMU samples them in its TLB state.
- Refill latency is 1 cycle. The entry is visible to lookups from the cycle after the `tlb_wvalid` edge.
- Lookup and refill of the same VPN in the same cycle return the old contents, i.e. a miss unless the configuration forwarding feature is enabled.
- There is no back-pressure: every `tlb_wvalid` pulse is accepted.
- Flush latency is 1 cycle. The lookup in the flush cycle still sees the old contents.

## Configuration
- `YSYX_23060236_TLB_WFWD_EN` defined: same-cycle write forwarding.
  - If `tlb_wvalid`=1, `tlb_flush`=0 and `tlb_awaddr == tlb_araddr`, then `tlb_hit`=1 and `tlb_rdata`=`tlb_wdata` in that cycle.
  - Forwarding takes priority over stored entries.
- Undefined: no forwarding. Lookup reflects stored state only, as described under Timing.
- Storage and replacement behaviour are identical in both builds.

## Structure
- A shared package holds:
  - `VPN_W`=20 and `PPN_W`=20.
  - The entry struct/typedef {valid, vpn, ppn}.
  - `TLB_IDX_W` = $clog2(ENTRIES) helper.
- One sub-module, `ysyx_23060236_tlb_victim`:
  - Inputs: valid vector and match vector.
  - Outputs: write index and `rr_ptr` advance enable.
  - Owns the `rr_ptr` register and the priority encoders.
- The top level holds the entry array, the lookup compare/mux and the forwarding mux.

## Test plan
- Reset, then lookup 0x12345 -> `tlb_hit`=0, `tlb_rdata`=0.
- Refill VPN 0x12345/PPN 0x80001, next cycle lookup 0x12345 -> hit=1, rdata=0x80001. Lookup 0x12346 -> hit=0.
- Fill 8 distinct VPNs 0x00001..0x00008, then refill 0x00009 -> entry 0 replaced.
  - Lookup 0x00001 misses and 0x00009 hits.
  - Refill 0x0000A replaces entry 1.
- Refill an existing VPN 0x00003 with new PPN 0x7FFFF -> hit returns 0x7FFFF. A following new VPN still evicts per `rr_ptr`, and no duplicate entry exists.
- `tlb_flush` and `tlb_wvalid` in the same cycle -> all lookups miss next cycle, including the written VPN, and `rr_ptr`=0.
- With `YSYX_23060236_TLB_WFWD_EN`: `tlb_wvalid`=1, awaddr=araddr=0x0ABCD, wdata=0x00042 -> hit=1, rdata=0x00042 in the same cycle. Without the macro -> hit=0 in that cycle and hit=1 the next cycle.
